// File: rtl/breath_mode_ctrl.sv
// breath_mode_ctrl
// Push-button front end for the breathing-LED stage. Synchronises and
// debounces one active-low key, classifies presses as short or long, and
// drives the period count / run enable / update strobe of the PWM stage.
//
// Optional feature macro: BREATH_MODE_LONGPRESS_EN
//   defined   : long press (LONG_CYC held cycles) toggles run, then waits
//               for release.
//   undefined : every press is a short press acted on at release; run = 1.
//
// Ports:
//   clk      in   system clock (12 MHz)
//   rst      in   asynchronous reset, active low
//   key_n    in   raw push button, low = pressed, asynchronous to clk
//   cnt_num  out  period count for the PWM stage, N[mode]
//   mode     out  current speed index 0..3
//   run      out  1 = breathing, 0 = paused
//   upd      out  one-cycle strobe when cnt_num or run changes
module breath_mode_ctrl #(
    parameter int unsigned DEB_CYC  = 240000,
    parameter int unsigned LONG_CYC = 12000000,
    parameter logic [12:0] N0       = 13'd1732,
    parameter logic [12:0] N1       = 13'd2449,
    parameter logic [12:0] N2       = 13'd3464,
    parameter logic [12:0] N3       = 13'd4899
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_n,
    output logic [12:0] cnt_num,
    output logic [1:0]  mode,
    output logic        run,
    output logic        upd
);

    localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_WAIT_REL
    } state_t;

    logic             key_meta_q;
    logic             key_s_q;
    logic             key_d_q, key_d_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             key_fall;
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [12:0]      cnt_num_q, cnt_num_d;
    logic             upd_q, upd_d;

`ifdef BREATH_MODE_LONGPRESS_EN
    localparam int unsigned HOLD_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);

    logic              run_q, run_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Debounce: count consecutive cycles where the synchronised level
    // disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
        key_d_d   = key_d_q;
        deb_cnt_d = '0;
        if (key_s_q != key_d_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                key_d_d = key_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Fall is taken from the next-state value so HELD starts in the same
    // cycle key_d drops; this makes the long-press action land exactly
    // LONG_CYC cycles after the debounced fall.
    assign key_fall = key_d_q & ~key_d_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        upd_d   = 1'b0;
`ifdef BREATH_MODE_LONGPRESS_EN
        run_d      = run_q;
        hold_cnt_d = hold_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (key_fall) begin
                    state_d = ST_HELD;
`ifdef BREATH_MODE_LONGPRESS_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_HELD: begin
`ifdef BREATH_MODE_LONGPRESS_EN
                if (hold_cnt_q == HOLD_MAX) begin
                    run_d   = ~run_q;
                    upd_d   = 1'b1;
                    state_d = ST_WAIT_REL;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (key_d_q) begin
                        mode_d  = mode_q + 2'd1;
                        upd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`else
                if (key_d_q) begin
                    mode_d  = mode_q + 2'd1;
                    upd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_WAIT_REL: begin
                if (key_d_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (mode_d)
            2'd0:    cnt_num_d = N0;
            2'd1:    cnt_num_d = N1;
            2'd2:    cnt_num_d = N2;
            default: cnt_num_d = N3;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            key_d_q    <= 1'b1;
            deb_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            mode_q     <= 2'd2;
            cnt_num_q  <= N2;
            upd_q      <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
            key_d_q    <= key_d_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_num_q  <= cnt_num_d;
            upd_q      <= upd_d;
        end
    end

`ifdef BREATH_MODE_LONGPRESS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b1;
            hold_cnt_q <= '0;
        end else begin
            run_q      <= run_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign run = run_q;
`else
    assign run = 1'b1;
`endif

    assign cnt_num = cnt_num_q;
    assign mode    = mode_q;
    assign upd     = upd_q;

endmodule
